// File: rtl/time_set_controller.sv
// rtl/time_set_controller.sv - button conditioning, mode FSM and tick/increment strobe generation
module time_set_controller #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SEC_CYCLES      = 100_000_000,
    parameter int FAST_DIV        = 60,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 20_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       speed_up,
    output logic [1:0] mode,
    output logic       tick_sec,
    output logic       inc_min,
    output logic       inc_hour,
    output logic       sec_clear
);

    localparam int DBW  = $clog2(DEBOUNCE_CYCLES);
    localparam int PW   = $clog2(SEC_CYCLES + 1);
    localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW   = $clog2(HMAX + 1);

    localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0]  SLOW_LAST = PW'(SEC_CYCLES - 1);
    localparam logic [PW-1:0]  FAST_LAST = PW'(SEC_CYCLES / FAST_DIV - 1);
    localparam logic [HW-1:0]  DELAY_L   = HW'(REPEAT_DELAY);
    localparam logic [HW-1:0]  PERIOD_L  = HW'(REPEAT_PERIOD);

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_HOUR = 2'b01,
        ST_MIN  = 2'b10
    } state_e;

    // Button bit 0 is mode, bit 1 is inc.
    logic [1:0]          sync1_q, sync1_d;
    logic [1:0]          sync2_q, sync2_d;
    logic [1:0]          db_q, db_d;
    logic [1:0]          db_prev_q, db_prev_d;
    logic [1:0]          press_q, press_d;
    logic [1:0][DBW-1:0] dcnt_q, dcnt_d;

    state_e              state_q, state_d;
    logic [PW-1:0]       pcnt_q, pcnt_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic                hold_act_q, hold_act_d;
    logic                rep_phase_q, rep_phase_d;
    logic                tick_q, tick_d;
    logic                inc_min_q, inc_min_d;
    logic                inc_hour_q, inc_hour_d;
    logic                sec_clear_q, sec_clear_d;

    logic                mode_press;
    logic                inc_press;
    logic [PW-1:0]       sec_last;
    logic [HW-1:0]       hold_limit;

    assign mode_press = press_q[0];
    assign inc_press  = press_q[1];
    assign sec_last   = speed_up ? FAST_LAST : SLOW_LAST;
    assign hold_limit = rep_phase_q ? PERIOD_L : DELAY_L;

    // Synchronize, debounce and edge-detect both buttons.
    always_comb begin
        sync1_d   = {btn_inc, btn_mode};
        sync2_d   = sync1_q;
        db_d      = db_q;
        dcnt_d    = dcnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (dcnt_q[i] == DB_LAST) begin
                    db_d[i]   = sync2_q[i];
                    dcnt_d[i] = '0;
                end else begin
                    dcnt_d[i] = dcnt_q[i] + 1'b1;
                end
            end else begin
                dcnt_d[i] = '0;
            end
        end
        db_prev_d = db_q;
        press_d   = db_q & ~db_prev_q;
    end

    // Mode FSM next state, prescaler, auto-repeat and strobe generation.
    always_comb begin
        state_d     = state_q;
        pcnt_d      = '0;
        hold_d      = '0;
        hold_act_d  = 1'b0;
        rep_phase_d = 1'b0;
        tick_d      = 1'b0;
        inc_min_d   = 1'b0;
        inc_hour_d  = 1'b0;
        sec_clear_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mode_press) begin
                    state_d = ST_HOUR;
                end else if (pcnt_q >= sec_last) begin
                    tick_d = 1'b1;
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
            ST_HOUR, ST_MIN: begin
                if (mode_press) begin
                    // Mode wins over a coincident inc press or repeat.
                    state_d     = (state_q == ST_HOUR) ? ST_MIN : ST_RUN;
                    sec_clear_d = (state_q == ST_MIN);
                end else if (inc_press) begin
                    inc_hour_d = (state_q == ST_HOUR);
                    inc_min_d  = (state_q == ST_MIN);
                    hold_act_d = 1'b1;
                    hold_d     = HW'(1);
                end else if (hold_act_q && db_q[1]) begin
                    hold_act_d  = 1'b1;
                    rep_phase_d = rep_phase_q;
                    if (hold_q == hold_limit) begin
                        inc_hour_d  = (state_q == ST_HOUR);
                        inc_min_d   = (state_q == ST_MIN);
                        hold_d      = HW'(1);
                        rep_phase_d = 1'b1;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            db_q        <= '0;
            db_prev_q   <= '0;
            press_q     <= '0;
            dcnt_q      <= '0;
            state_q     <= ST_RUN;
            pcnt_q      <= '0;
            hold_q      <= '0;
            hold_act_q  <= 1'b0;
            rep_phase_q <= 1'b0;
            tick_q      <= 1'b0;
            inc_min_q   <= 1'b0;
            inc_hour_q  <= 1'b0;
            sec_clear_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            db_q        <= db_d;
            db_prev_q   <= db_prev_d;
            press_q     <= press_d;
            dcnt_q      <= dcnt_d;
            state_q     <= state_d;
            pcnt_q      <= pcnt_d;
            hold_q      <= hold_d;
            hold_act_q  <= hold_act_d;
            rep_phase_q <= rep_phase_d;
            tick_q      <= tick_d;
            inc_min_q   <= inc_min_d;
            inc_hour_q  <= inc_hour_d;
            sec_clear_q <= sec_clear_d;
        end
    end

    assign mode      = state_q;
    assign tick_sec  = tick_q;
    assign inc_min   = inc_min_q;
    assign inc_hour  = inc_hour_q;
    assign sec_clear = sec_clear_q;

endmodule

// File: doc/time_set_controller.md
# time_set_controller

Sequencer for the clock's time-keeping counters. It turns raw front-panel buttons into debounced commands, runs a mode state machine (run / set hours / set minutes), and generates the one-cycle strobes that advance the seconds, minutes and hours counters. It accepts the `speed_up` level from the switch edge detector and uses it to accelerate the seconds strobe. It sits between the panel inputs and the time counter chain; it owns no time digits itself.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required before a button level is accepted (≥2).
- `SEC_CYCLES`, default 100_000_000: clk cycles per `tick_sec` in normal run.
- `FAST_DIV`, default 60: speed-up divisor. Fast period is `SEC_CYCLES/FAST_DIV` (integer division, must be ≥1).
- `REPEAT_DELAY`, default 50_000_000: held-button cycles from the initial inc pulse to the first auto-repeat pulse.
- `REPEAT_PERIOD`, default 20_000_000: cycles between subsequent auto-repeat pulses.
- `clk` input 1: single system clock; all logic is on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `btn_mode` input 1: raw, asynchronous mode button, active high.
- `btn_inc` input 1: raw, asynchronous increment button, active high.
- `speed_up` input 1: synchronous level from the switch edge detector.
- `mode` output 2: 2'b00 RUN, 2'b01 SET_HOUR, 2'b10 SET_MIN. 2'b11 is never driven.
- `tick_sec` output 1: one-cycle strobe that advances seconds.
- `inc_min` output 1: one-cycle strobe that increments minutes.
- `inc_hour` output 1: one-cycle strobe that increments hours.
- `sec_clear` output 1: one-cycle strobe that zeroes seconds.

## Operation
- **Input conditioning.** Each button goes through a 2-flop synchronizer, then a debouncer with counter `cnt` and level `db`.
  - When sync ≠ `db`: if `cnt == DEBOUNCE_CYCLES-1`, then `db <= sync` and `cnt <= 0`; otherwise `cnt++`.
  - When sync == `db`: `cnt <= 0`.
- **Press events.** A press is a registered rising-edge detect of `db` and lasts exactly one cycle. Releases generate no event.
- **FSM transitions** occur on a mode press: RUN→SET_HOUR→SET_MIN→RUN.
  - On the SET_MIN→RUN transition, `sec_clear` pulses and the prescaler restarts at 0.
- **RUN.**
  - The prescaler counts 0..L-1, where L = `speed_up` ? `SEC_CYCLES/FAST_DIV` : `SEC_CYCLES`.
  - On any cycle with `cnt ≥ L-1`: `tick_sec` = 1 and `cnt <= 0`. This covers a `speed_up` rise while `cnt` exceeds the fast limit: tick on the next edge.
  - Inc presses are ignored.
- **SET_HOUR / SET_MIN.**
  - The prescaler is held at 0 and `tick_sec` = 0.
  - An inc press emits one `inc_hour` or `inc_min` pulse, matching the current state.
  - While inc `db` stays 1, the first repeat pulse comes `REPEAT_DELAY` cycles after the initial pulse, then one pulse every `REPEAT_PERIOD` cycles.
  - Release (`db` = 0) or any mode change cancels the repeat and clears the hold counter.
- **Simultaneous mode and inc presses in one cycle:** mode wins and no inc pulse is emitted. The repeat pulse due that cycle is suppressed as well.
- **At most one** of `tick_sec`, `inc_min`, `inc_hour` is high in any cycle.

## Timing
- **Reset values:** `mode` = 2'b00; `tick_sec`, `inc_min`, `inc_hour`, `sec_clear` = 0; all counters, synchronizers, `db` and edge registers = 0.
- **Reset mid-operation:** reset takes effect immediately (asynchronous). Any pending repeat or partially debounced press is discarded. Release is synchronous in effect: all logic restarts from the reset state on the first edge after `rst_n` rises.
- **All outputs are registered.**
- **Button latency.** Let edge 1 be the first clk edge that samples the new raw level; with N = `DEBOUNCE_CYCLES`:
  - `db` changes at edge N+2.
  - The press pulse is high after edge N+3.
  - `mode` changes, or the first `inc_*` pulse asserts, at edge N+4.
- **`sec_clear`** asserts on the same edge that `mode` becomes RUN.
- **Bounce shorter than N stable cycles** produces no event.
- **`tick_sec` period:** exactly L cycles while L is constant. The first tick after entering RUN is L cycles after the mode change.

## Test plan
Parameters for all scenarios: DEBOUNCE_CYCLES=4, SEC_CYCLES=20, FAST_DIV=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.

1. **Reset then idle.**
   - Stimulus: reset, then idle 100 cycles with `speed_up`=0.
   - Required: `mode`=00; `tick_sec` every 20 cycles, first at cycle 20 after reset release.
2. **Speed-up switching.**
   - Stimulus: raise `speed_up` when prescaler `cnt`=12.
   - Required: tick on the next edge, then every 5 cycles. Dropping `speed_up` restores the 20-cycle period.
3. **Bouncy mode button.**
   - Stimulus: `btn_mode` bounces (high 2, low 1, high 3 cycles), then stays high.
   - Required: exactly one mode change, 8 edges after the final stable sample; `mode`=01.
4. **Mode cycle and seconds clear.**
   - Stimulus: three clean mode presses.
   - Required: `mode` 01→10→00; `sec_clear` pulses once on the →00 edge; no `tick_sec` while in 01/10; next tick 20 cycles later.
5. **Auto-repeat.**
   - Stimulus: in SET_MIN, hold `btn_inc` for 30 debounced-high cycles.
   - Required: `inc_min` pulses at relative cycles 0, 10, 13, 16, 19, 22, 25, 28; none after release; `inc_hour` stays 0.
6. **Collision and reset.**
   - Stimulus: mode and inc presses land on the same cycle in SET_HOUR; separately, assert `rst_n`=0 mid-repeat.
   - Required: the collision gives `mode`→10 with no `inc_hour`. The reset forces all outputs 0 and `mode`=00 immediately.
